jenc_frame_ctrl: RTL and testbench
==================================

Name: jenc_frame_ctrl

Overview:
- Per-frame sequencer for the JPEG encoder pipeline (dct_2d → quant → entropy → bitpacker → bytepacker).
- Latches frame geometry at start, pulses the encoder size clear, gates the pixel stream into the encoder, and watches the output stream for the last beat.
- Latches the final compressed size and reports done/error to the camera register interface.
- Includes a progress watchdog that terminates a stalled frame.

Parameters:
- SENSOR_X_SIZE, 720, max frame width; XW = $clog2(SENSOR_X_SIZE).
- SENSOR_Y_SIZE, 720, max frame height; YW = $clog2(SENSOR_Y_SIZE).
- TIMEOUT_CYCLES, 1048576, number of cycles without any input or output beat before a frame is declared stalled.
- FLUSH_CYCLES, 2, settle cycles after the output tlast before the encoder size is sampled.

Ports:
- clk  in  1  sole clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request to encode one frame.
- abort  in  1  single-cycle request to cancel the current frame.
- cfg_x_size_m1  in  XW  requested width minus 1.
- cfg_y_size_m1  in  YW  requested height minus 1.
- enc_x_size_m1  out  XW  latched width sent to the encoder.
- enc_y_size_m1  out  YW  latched height sent to the encoder.
- src_valid  in  1  upstream pixel beat valid.
- src_hold  out  1  backpressure to upstream.
- enc_di_valid  out  1  gated valid to the encoder.
- enc_di_hold  in  1  encoder backpressure.
- enc_out_valid  in  1  encoder output valid (monitored only).
- enc_out_hold  in  1  sink hold (monitored only).
- enc_out_tlast  in  1  encoder output last beat.
- enc_size  in  20  encoder byte count.
- enc_size_clear  out  1  clear pulse to the encoder size counter.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a frame completes.
- error  out  1  sticky watchdog flag.
- frame_size  out  20  compressed bytes of the last completed frame.
- in_beats  out  17  input beats accepted in the current or last frame; saturates at all-ones.

Behaviour:
- Reset values:
  - State IDLE.
  - enc_x_size_m1 = SENSOR_X_SIZE-1; enc_y_size_m1 = SENSOR_Y_SIZE-1.
  - src_hold = 1.
  - enc_di_valid, enc_size_clear, busy, done and error = 0.
  - frame_size and in_beats = 0.
  - Watchdog counter and flush counter = 0.
- Beat definitions:
  - Input beat accepted = enc_di_valid && !enc_di_hold.
  - Output beat accepted = enc_out_valid && !enc_out_hold.
- IDLE:
  - src_hold = 1; enc_di_valid = 0.
  - start && !abort: latch cfg_*_size_m1 into enc_*_size_m1, clear error, clear in_beats, go to CLEAR.
  - start && abort in the same cycle: stay in IDLE and change nothing.
- CLEAR: enc_size_clear = 1 for exactly this one cycle, then go to ENCODE.
- ENCODE:
  - enc_di_valid = src_valid and src_hold = enc_di_hold, both combinational.
  - in_beats increments on each accepted input beat.
  - Output beat accepted with enc_out_tlast → go to FLUSH with flush counter = 0.
- FLUSH:
  - src_hold = 1; enc_di_valid = 0.
  - Stay FLUSH_CYCLES cycles.
  - On the last cycle: frame_size ← enc_size, done = 1 next cycle, go to IDLE.
- Watchdog (ENCODE only):
  - Counter resets to 0 on entry and on any accepted input or output beat; otherwise increments.
  - At TIMEOUT_CYCLES-1 → go to ERROR.
- ERROR:
  - Lasts one cycle: error ← 1, src_hold = 1, enc_di_valid = 0, then go to IDLE.
  - No done pulse; frame_size unchanged.
  - error stays set until the next accepted start.
- Abort:
  - In CLEAR, ENCODE or FLUSH: go to IDLE next cycle.
  - No done pulse; error, frame_size and in_beats unchanged.
- Start while busy is ignored; enc_*_size_m1 stay stable for the whole frame.
- Precedence within a cycle: abort > watchdog timeout > tlast.
- Reset asserted mid-frame returns all outputs to their reset values immediately; no done pulse.
- enc_size_clear never asserts outside CLEAR; done never coincides with busy = 1 beyond the FLUSH exit cycle.

Test Plan:
- Nominal frame:
  - cfg 63/63, start, 512 input beats, 40 output beats with tlast on the last, enc_size = 1234.
  - Expect: exactly 1 enc_size_clear pulse; done pulse FLUSH_CYCLES+1 cycles after tlast acceptance; frame_size = 1234; in_beats = 512; busy falls with done.
- Backpressure:
  - enc_di_hold toggled 50% during ENCODE.
  - Expect: src_hold mirrors enc_di_hold cycle-for-cycle; in_beats counts only accepted beats.
  - tlast presented with enc_out_hold = 1 must not advance the FSM until hold drops.
- Watchdog:
  - TIMEOUT_CYCLES = 16, no beats after start.
  - Expect: ERROR 16 cycles after entering ENCODE; error = 1; no done; next start clears error.
- Abort mid-ENCODE after 10 beats:
  - Expect: IDLE next cycle; src_hold = 1; in_beats = 10; frame_size keeps its previous value.
  - start && abort in IDLE → no state change.
- Start ignored while busy:
  - start pulsed in ENCODE with cfg 15/15.
  - Expect: enc_x/y_size_m1 unchanged and no second enc_size_clear.
- Async reset asserted in FLUSH:
  - Expect: outputs at reset values without a clock edge; no done pulse after release.

Source files
------------

// File: rtl/jenc_frame_ctrl_if.sv
// Control/stream bundle between the JPEG frame sequencer and its surroundings.
// The master modport is the sequencer's view; the slave modport is the camera/encoder side.
interface jenc_frame_ctrl_if #(
   parameter int XW = 10,
   parameter int YW = 10
);
   logic          start;
   logic          abort;
   logic [XW-1:0] cfg_x_size_m1;
   logic [YW-1:0] cfg_y_size_m1;
   logic [XW-1:0] enc_x_size_m1;
   logic [YW-1:0] enc_y_size_m1;
   logic          src_valid;
   logic          src_hold;
   logic          enc_di_valid;
   logic          enc_di_hold;
   logic          enc_out_valid;
   logic          enc_out_hold;
   logic          enc_out_tlast;
   logic [19:0]   enc_size;
   logic          enc_size_clear;
   logic          busy;
   logic          done;
   logic          error;
   logic [19:0]   frame_size;
   logic [16:0]   in_beats;

   modport master (
      input  start, abort, cfg_x_size_m1, cfg_y_size_m1,
      input  src_valid, enc_di_hold, enc_out_valid, enc_out_hold, enc_out_tlast, enc_size,
      output enc_x_size_m1, enc_y_size_m1, src_hold, enc_di_valid, enc_size_clear,
      output busy, done, error, frame_size, in_beats
   );

   modport slave (
      output start, abort, cfg_x_size_m1, cfg_y_size_m1,
      output src_valid, enc_di_hold, enc_out_valid, enc_out_hold, enc_out_tlast, enc_size,
      input  enc_x_size_m1, enc_y_size_m1, src_hold, enc_di_valid, enc_size_clear,
      input  busy, done, error, frame_size, in_beats
   );
endinterface

// File: rtl/jenc_frame_ctrl.sv
// Per-frame sequencer for the JPEG encoder: latches geometry, clears the size counter,
// gates pixels in, waits for the output tlast, and reports size/done/error with a stall watchdog.
module jenc_frame_ctrl #(
   parameter int SENSOR_X_SIZE  = 720,
   parameter int SENSOR_Y_SIZE  = 720,
   parameter int TIMEOUT_CYCLES = 1048576,
   parameter int FLUSH_CYCLES   = 2
) (
   input  logic              clk,
   input  logic              reset,
   jenc_frame_ctrl_if.master bus
);
   localparam int XW  = $clog2(SENSOR_X_SIZE);
   localparam int YW  = $clog2(SENSOR_Y_SIZE);
   localparam int WDW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int FCW = $clog2(FLUSH_CYCLES + 1);
   localparam logic [XW-1:0]  X_RST      = XW'(SENSOR_X_SIZE - 1);
   localparam logic [YW-1:0]  Y_RST      = YW'(SENSOR_Y_SIZE - 1);
   localparam logic [WDW-1:0] WD_LIMIT   = WDW'(TIMEOUT_CYCLES - 1);
   localparam logic [FCW-1:0] FLUSH_LAST = FCW'(FLUSH_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_ENCODE,
      S_FLUSH,
      S_ERROR
   } state_t;

   state_t         state_reg;
   state_t         state_next;
   logic [XW-1:0]  x_size_reg;
   logic [YW-1:0]  y_size_reg;
   logic           error_reg;
   logic           done_reg;
   logic [19:0]    frame_size_reg;
   logic [16:0]    in_beats_reg;
   logic [WDW-1:0] wd_reg;
   logic [FCW-1:0] flush_reg;

   logic di_valid;
   logic src_hold;
   logic size_clear;
   logic start_ok;
   logic in_beat;
   logic out_beat;
   logic wd_expired;
   logic flush_last;

   assign start_ok   = bus.start && !bus.abort;
   assign in_beat    = di_valid && !bus.enc_di_hold;
   assign out_beat   = bus.enc_out_valid && !bus.enc_out_hold;
   assign wd_expired = (wd_reg == WD_LIMIT);
   assign flush_last = (flush_reg == FLUSH_LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= S_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Abort outranks the watchdog, which outranks tlast.
   always_comb begin
      state_next = state_reg;
      di_valid   = 1'b0;
      src_hold   = 1'b1;
      size_clear = 1'b0;
      case (state_reg)
         S_IDLE: begin
            if (start_ok) state_next = S_CLEAR;
         end
         S_CLEAR: begin
            size_clear = 1'b1;
            state_next = bus.abort ? S_IDLE : S_ENCODE;
         end
         S_ENCODE: begin
            di_valid = bus.src_valid;
            src_hold = bus.enc_di_hold;
            if (bus.abort)                            state_next = S_IDLE;
            else if (wd_expired)                      state_next = S_ERROR;
            else if (out_beat && bus.enc_out_tlast)   state_next = S_FLUSH;
         end
         S_FLUSH: begin
            if (bus.abort || flush_last) state_next = S_IDLE;
         end
         S_ERROR: begin
            state_next = S_IDLE;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         x_size_reg     <= X_RST;
         y_size_reg     <= Y_RST;
         error_reg      <= 1'b0;
         done_reg       <= 1'b0;
         frame_size_reg <= '0;
         in_beats_reg   <= '0;
         wd_reg         <= '0;
         flush_reg      <= '0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            S_IDLE: begin
               if (start_ok) begin
                  x_size_reg   <= bus.cfg_x_size_m1;
                  y_size_reg   <= bus.cfg_y_size_m1;
                  error_reg    <= 1'b0;
                  in_beats_reg <= '0;
               end
            end
            S_CLEAR: begin
               wd_reg <= '0;
            end
            S_ENCODE: begin
               if (in_beat && (in_beats_reg != '1)) in_beats_reg <= in_beats_reg + 1'b1;
               if (in_beat || out_beat) wd_reg <= '0;
               else                     wd_reg <= wd_reg + 1'b1;
               flush_reg <= '0;
            end
            S_FLUSH: begin
               flush_reg <= flush_reg + 1'b1;
               // Size is sampled only after the settle window so the bytepacker has drained.
               if (!bus.abort && flush_last) begin
                  frame_size_reg <= bus.enc_size;
                  done_reg       <= 1'b1;
               end
            end
            S_ERROR: begin
               error_reg <= 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.enc_x_size_m1  = x_size_reg;
   assign bus.enc_y_size_m1  = y_size_reg;
   assign bus.src_hold       = src_hold;
   assign bus.enc_di_valid   = di_valid;
   assign bus.enc_size_clear = size_clear;
   assign bus.busy           = (state_reg != S_IDLE);
   assign bus.done           = done_reg;
   assign bus.error          = error_reg;
   assign bus.frame_size     = frame_size_reg;
   assign bus.in_beats       = in_beats_reg;
endmodule

// File: tb/tb_jenc_frame_ctrl.sv
// Directed bench for jenc_frame_ctrl: nominal frame, backpressure, watchdog, abort,
// start-while-busy and asynchronous reset during FLUSH.
module tb_jenc_frame_ctrl;
   localparam int XW = 10;
   localparam int YW = 10;

   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   bad = 0;
   int   clear_cnt = 0;
   int   done_cnt = 0;

   jenc_frame_ctrl_if #(.XW(XW), .YW(YW)) bus ();

   jenc_frame_ctrl #(
      .SENSOR_X_SIZE (720),
      .SENSOR_Y_SIZE (720),
      .TIMEOUT_CYCLES(16),
      .FLUSH_CYCLES  (2)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (bus.enc_size_clear === 1'b1) clear_cnt++;
      if (bus.done === 1'b1) done_cnt++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.src_valid = 1'b1;
      tick();
      tick();
      #1;
      total++; if (bus.src_hold !== 1'b1) begin bad++; $display("FAIL rst_src_hold: got %0b want 1", bus.src_hold); end
      total++; if (bus.enc_di_valid !== 1'b0) begin bad++; $display("FAIL rst_di_valid: got %0b want 0", bus.enc_di_valid); end
      total++; if (bus.enc_x_size_m1 !== 10'd719) begin bad++; $display("FAIL rst_x: got %0d want 719", bus.enc_x_size_m1); end
      total++; if (bus.enc_y_size_m1 !== 10'd719) begin bad++; $display("FAIL rst_y: got %0d want 719", bus.enc_y_size_m1); end
      total++; if ({bus.busy, bus.done, bus.error, bus.enc_size_clear} !== 4'b0) begin bad++; $display("FAIL rst_flags: got %b want 0000", {bus.busy, bus.done, bus.error, bus.enc_size_clear}); end
      total++; if (bus.frame_size !== 20'd0 || bus.in_beats !== 17'd0) begin bad++; $display("FAIL rst_counts: got fs=%0d ib=%0d want 0/0", bus.frame_size, bus.in_beats); end
      bus.src_valid = 1'b0;
      reset = 1'b0;
      tick();
      $display("reset: checked");
   endtask

   task automatic test_nominal();
      int c0;
      int d0;
      c0 = clear_cnt;
      d0 = done_cnt;
      bus.cfg_x_size_m1 = 10'd63;
      bus.cfg_y_size_m1 = 10'd63;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      #1;
      total++; if (bus.enc_size_clear !== 1'b1 || bus.busy !== 1'b1) begin bad++; $display("FAIL nom_clear: got clr=%0b busy=%0b want 1/1", bus.enc_size_clear, bus.busy); end
      total++; if (bus.enc_x_size_m1 !== 10'd63 || bus.enc_y_size_m1 !== 10'd63) begin bad++; $display("FAIL nom_geom: got %0d/%0d want 63/63", bus.enc_x_size_m1, bus.enc_y_size_m1); end
      tick();
      bus.src_valid = 1'b1;
      bus.enc_di_hold = 1'b0;
      bus.enc_size = 20'd1234;
      for (int i = 0; i < 512; i++) begin
         #1;
         total++; if (bus.enc_di_valid !== 1'b1) begin bad++; $display("FAIL nom_di_valid[%0d]: got %0b want 1", i, bus.enc_di_valid); end
         tick();
      end
      bus.src_valid = 1'b0;
      for (int i = 0; i < 40; i++) begin
         bus.enc_out_valid = 1'b1;
         bus.enc_out_tlast = (i == 39);
         tick();
      end
      bus.enc_out_valid = 1'b0;
      bus.enc_out_tlast = 1'b0;
      #1;
      total++; if (bus.busy !== 1'b1 || bus.src_hold !== 1'b1 || bus.done !== 1'b0) begin bad++; $display("FAIL nom_flush1: got busy=%0b hold=%0b done=%0b want 1/1/0", bus.busy, bus.src_hold, bus.done); end
      tick();
      total++; if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin bad++; $display("FAIL nom_flush2: got done=%0b busy=%0b want 0/1", bus.done, bus.busy); end
      tick();
      total++; if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin bad++; $display("FAIL nom_done: got done=%0b busy=%0b want 1/0", bus.done, bus.busy); end
      total++; if (bus.frame_size !== 20'd1234) begin bad++; $display("FAIL nom_frame_size: got %0d want 1234", bus.frame_size); end
      total++; if (bus.in_beats !== 17'd512) begin bad++; $display("FAIL nom_in_beats: got %0d want 512", bus.in_beats); end
      tick();
      total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL nom_done_pulse: got %0b want 0", bus.done); end
      total++; if (clear_cnt - c0 != 1) begin bad++; $display("FAIL nom_clear_count: got %0d want 1", clear_cnt - c0); end
      total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL nom_done_count: got %0d want 1", done_cnt - d0); end
      $display("nominal: frame_size=%0d in_beats=%0d", bus.frame_size, bus.in_beats);
   endtask

   task automatic test_backpressure();
      logic h;
      bus.cfg_x_size_m1 = 10'd7;
      bus.cfg_y_size_m1 = 10'd7;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      tick();
      bus.src_valid = 1'b1;
      bus.enc_size = 20'd555;
      for (int i = 0; i < 20; i++) begin
         h = (i % 2 == 1);
         bus.enc_di_hold = h;
         #1;
         total++; if (bus.src_hold !== h) begin bad++; $display("FAIL bp_src_hold[%0d]: got %0b want %0b", i, bus.src_hold, h); end
         tick();
      end
      bus.src_valid = 1'b0;
      bus.enc_di_hold = 1'b0;
      bus.enc_out_valid = 1'b1;
      bus.enc_out_tlast = 1'b1;
      bus.enc_out_hold = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         total++; if (bus.src_hold !== 1'b0 || bus.busy !== 1'b1) begin bad++; $display("FAIL bp_tlast_held[%0d]: got hold=%0b busy=%0b want 0/1", i, bus.src_hold, bus.busy); end
      end
      bus.enc_out_hold = 1'b0;
      tick();
      bus.enc_out_valid = 1'b0;
      bus.enc_out_tlast = 1'b0;
      #1;
      total++; if (bus.src_hold !== 1'b1 || bus.busy !== 1'b1) begin bad++; $display("FAIL bp_flush: got hold=%0b busy=%0b want 1/1", bus.src_hold, bus.busy); end
      tick();
      tick();
      total++; if (bus.done !== 1'b1 || bus.frame_size !== 20'd555) begin bad++; $display("FAIL bp_done: got done=%0b fs=%0d want 1/555", bus.done, bus.frame_size); end
      total++; if (bus.in_beats !== 17'd10) begin bad++; $display("FAIL bp_in_beats: got %0d want 10", bus.in_beats); end
      tick();
      $display("backpressure: in_beats=%0d frame_size=%0d", bus.in_beats, bus.frame_size);
   endtask

   task automatic test_watchdog();
      int d0;
      d0 = done_cnt;
      bus.cfg_x_size_m1 = 10'd31;
      bus.cfg_y_size_m1 = 10'd31;
      bus.enc_di_hold = 1'b0;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      tick();
      repeat (15) tick();
      total++; if (bus.busy !== 1'b1 || bus.src_hold !== 1'b0) begin bad++; $display("FAIL wd_encode15: got busy=%0b hold=%0b want 1/0", bus.busy, bus.src_hold); end
      tick();
      total++; if (bus.busy !== 1'b1 || bus.src_hold !== 1'b1 || bus.error !== 1'b0) begin bad++; $display("FAIL wd_error_state: got busy=%0b hold=%0b err=%0b want 1/1/0", bus.busy, bus.src_hold, bus.error); end
      tick();
      total++; if (bus.busy !== 1'b0 || bus.error !== 1'b1) begin bad++; $display("FAIL wd_error_flag: got busy=%0b err=%0b want 0/1", bus.busy, bus.error); end
      total++; if (bus.frame_size !== 20'd555) begin bad++; $display("FAIL wd_frame_size: got %0d want 555", bus.frame_size); end
      tick();
      total++; if (bus.error !== 1'b1 || done_cnt != d0) begin bad++; $display("FAIL wd_sticky: got err=%0b dones=%0d want 1/0", bus.error, done_cnt - d0); end
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      #1;
      total++; if (bus.error !== 1'b0 || bus.busy !== 1'b1) begin bad++; $display("FAIL wd_restart: got err=%0b busy=%0b want 0/1", bus.error, bus.busy); end
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL wd_abort_clear: got busy=%0b want 0", bus.busy); end
      $display("watchdog: error raised and cleared");
   endtask

   task automatic test_abort();
      int c0;
      bus.cfg_x_size_m1 = 10'd20;
      bus.cfg_y_size_m1 = 10'd21;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      tick();
      bus.src_valid = 1'b1;
      repeat (10) tick();
      bus.src_valid = 1'b0;
      bus.abort = 1'b1;
      #1;
      total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL ab_pre: got busy=%0b want 1", bus.busy); end
      tick();
      bus.abort = 1'b0;
      total++; if (bus.busy !== 1'b0 || bus.src_hold !== 1'b1) begin bad++; $display("FAIL ab_idle: got busy=%0b hold=%0b want 0/1", bus.busy, bus.src_hold); end
      total++; if (bus.in_beats !== 17'd10 || bus.frame_size !== 20'd555) begin bad++; $display("FAIL ab_counts: got ib=%0d fs=%0d want 10/555", bus.in_beats, bus.frame_size); end
      tick();
      total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL ab_no_done: got %0b want 0", bus.done); end
      c0 = clear_cnt;
      bus.cfg_x_size_m1 = 10'd3;
      bus.cfg_y_size_m1 = 10'd3;
      bus.start = 1'b1;
      bus.abort = 1'b1;
      tick();
      bus.start = 1'b0;
      bus.abort = 1'b0;
      tick();
      total++; if (bus.busy !== 1'b0 || bus.enc_x_size_m1 !== 10'd20 || bus.enc_y_size_m1 !== 10'd21) begin bad++; $display("FAIL ab_start_abort: got busy=%0b x=%0d y=%0d want 0/20/21", bus.busy, bus.enc_x_size_m1, bus.enc_y_size_m1); end
      total++; if (clear_cnt != c0 || bus.in_beats !== 17'd10) begin bad++; $display("FAIL ab_start_abort_side: got clears=%0d ib=%0d want 0/10", clear_cnt - c0, bus.in_beats); end
      $display("abort: in_beats=%0d", bus.in_beats);
   endtask

   task automatic test_start_busy();
      int c0;
      c0 = clear_cnt;
      bus.cfg_x_size_m1 = 10'd40;
      bus.cfg_y_size_m1 = 10'd41;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      tick();
      bus.src_valid = 1'b1;
      repeat (5) tick();
      bus.cfg_x_size_m1 = 10'd15;
      bus.cfg_y_size_m1 = 10'd15;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      repeat (5) tick();
      total++; if (bus.enc_x_size_m1 !== 10'd40 || bus.enc_y_size_m1 !== 10'd41) begin bad++; $display("FAIL sb_geom: got %0d/%0d want 40/41", bus.enc_x_size_m1, bus.enc_y_size_m1); end
      bus.src_valid = 1'b0;
      bus.enc_size = 20'd77;
      bus.enc_out_valid = 1'b1;
      bus.enc_out_tlast = 1'b1;
      tick();
      bus.enc_out_valid = 1'b0;
      bus.enc_out_tlast = 1'b0;
      tick();
      tick();
      total++; if (bus.done !== 1'b1 || bus.frame_size !== 20'd77 || bus.in_beats !== 17'd11) begin bad++; $display("FAIL sb_done: got done=%0b fs=%0d ib=%0d want 1/77/11", bus.done, bus.frame_size, bus.in_beats); end
      tick();
      total++; if (clear_cnt - c0 != 1) begin bad++; $display("FAIL sb_clear_count: got %0d want 1", clear_cnt - c0); end
      $display("start_busy: frame_size=%0d in_beats=%0d", bus.frame_size, bus.in_beats);
   endtask

   task automatic test_reset_flush();
      int d0;
      d0 = done_cnt;
      bus.cfg_x_size_m1 = 10'd9;
      bus.cfg_y_size_m1 = 10'd9;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      tick();
      bus.src_valid = 1'b1;
      repeat (3) tick();
      bus.src_valid = 1'b0;
      bus.enc_out_valid = 1'b1;
      bus.enc_out_tlast = 1'b1;
      tick();
      bus.enc_out_valid = 1'b0;
      bus.enc_out_tlast = 1'b0;
      bus.src_valid = 1'b1;
      #1;
      total++; if (bus.busy !== 1'b1 || bus.src_hold !== 1'b1) begin bad++; $display("FAIL rf_in_flush: got busy=%0b hold=%0b want 1/1", bus.busy, bus.src_hold); end
      reset = 1'b1;
      #1;
      total++; if (bus.busy !== 1'b0 || bus.src_hold !== 1'b1 || bus.enc_di_valid !== 1'b0) begin bad++; $display("FAIL rf_async_ctrl: got busy=%0b hold=%0b dv=%0b want 0/1/0", bus.busy, bus.src_hold, bus.enc_di_valid); end
      total++; if (bus.enc_x_size_m1 !== 10'd719 || bus.enc_y_size_m1 !== 10'd719) begin bad++; $display("FAIL rf_async_geom: got %0d/%0d want 719/719", bus.enc_x_size_m1, bus.enc_y_size_m1); end
      total++; if (bus.frame_size !== 20'd0 || bus.in_beats !== 17'd0 || bus.done !== 1'b0) begin bad++; $display("FAIL rf_async_counts: got fs=%0d ib=%0d done=%0b want 0/0/0", bus.frame_size, bus.in_beats, bus.done); end
      bus.src_valid = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      repeat (4) tick();
      total++; if (done_cnt != d0 || bus.busy !== 1'b0 || bus.frame_size !== 20'd0) begin bad++; $display("FAIL rf_after: got dones=%0d busy=%0b fs=%0d want 0/0/0", done_cnt - d0, bus.busy, bus.frame_size); end
      $display("reset_flush: outputs returned to reset values");
   endtask

   initial begin
      reset = 1'b1;
      bus.start = 1'b0;
      bus.abort = 1'b0;
      bus.cfg_x_size_m1 = '0;
      bus.cfg_y_size_m1 = '0;
      bus.src_valid = 1'b0;
      bus.enc_di_hold = 1'b0;
      bus.enc_out_valid = 1'b0;
      bus.enc_out_hold = 1'b0;
      bus.enc_out_tlast = 1'b0;
      bus.enc_size = '0;
      test_reset();
      test_nominal();
      test_backpressure();
      test_watchdog();
      test_abort();
      test_start_busy();
      test_reset_flush();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
